// File: rtl/bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: handshake codes,
// arbiter state encoding and a one-hot to index helper.
package bus_pkg;

   localparam int DATA_W_DEF = 16;

   localparam logic [1:0] SEND_IDLE = 2'b00;
   localparam logic [1:0] SEND_REQ  = 2'b01;

   localparam logic [1:0] ACK_NONE  = 2'b00;
   localparam logic [1:0] ACK_DONE  = 2'b01;
   localparam logic [1:0] ACK_RETRY = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_XFER    = 2'b01,
      ST_RELEASE = 2'b10
   } arb_state_t;

   // Index of the set bit in a one-hot vector (up to 8 slots); 0 when empty.
   function automatic logic [2:0] onehot_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin selector: first requesting slot after 'last',
// wrapping modulo NREQ, so the previous winner has the lowest priority.
module bus_rr_picker #(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] last,
   output logic [NREQ-1:0]  pick,
   output logic             valid
);

   always_comb begin
      int idx;
      idx   = 0;
      pick  = '0;
      valid = 1'b0;
      for (int off = 1; off <= NREQ; off++) begin
         idx = (int'(last) + off) % NREQ;
         if (!valid && req[idx]) begin
            pick[idx] = 1'b1;
            valid     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one target channel among NREQ send/ack requesters.
// Optional transfer timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [2*NREQ-1:0]      req_send,
   input  logic [DATA_W*NREQ-1:0] req_dado,
   output logic [2*NREQ-1:0]      req_ack,
   output logic [NREQ-1:0]        grant,
   output logic                   busy,
   output logic [1:0]             tgt_send,
   output logic [DATA_W-1:0]      tgt_dado,
   input  logic [1:0]             tgt_ack
);

   localparam int IDX_W = $clog2(NREQ);

   arb_state_t        state_reg, state_next;
   logic [NREQ-1:0]   grant_reg, grant_next;
   logic [DATA_W-1:0] tgt_dado_reg, tgt_dado_next;
   logic [1:0]        tgt_send_reg, tgt_send_next;
   logic [1:0]        ack_code_reg, ack_code_next;
   logic [2*NREQ-1:0] req_ack_reg, req_ack_next;
   logic              busy_reg, busy_next;
   logic [IDX_W-1:0]  last_reg, last_next;

   logic [NREQ-1:0]   req_vec;
   logic [NREQ-1:0]   pick;
   logic              pick_valid;
   logic [DATA_W-1:0] sel_dado;

   // Only the exact code 01 is a request; 1x counts as idle.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_vec[gi] = (req_send[2*gi +: 2] == SEND_REQ);
   end

   bus_rr_picker #(
      .NREQ (NREQ),
      .IDX_W(IDX_W)
   ) u_picker (
      .req  (req_vec),
      .last (last_reg),
      .pick (pick),
      .valid(pick_valid)
   );

   always_comb begin
      sel_dado = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (pick[i]) sel_dado = sel_dado | req_dado[DATA_W*i +: DATA_W];
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   // Counts XFER cycles; IDLE and RELEASE keep it at zero so entry starts fresh.
   always_comb begin
      cnt_next = '0;
      if (state_reg == ST_XFER) cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= cnt_next;
   end
`endif

   always_comb begin
      state_next    = state_reg;
      grant_next    = grant_reg;
      tgt_dado_next = tgt_dado_reg;
      ack_code_next = ack_code_reg;
      last_next     = last_reg;

      unique case (state_reg)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_next    = pick;
               tgt_dado_next = sel_dado;
               ack_code_next = ACK_NONE;
               state_next    = ST_XFER;
            end
         end
         ST_XFER: begin
            // A real target response takes precedence over timeout expiry.
            if (tgt_ack == ACK_DONE || tgt_ack == ACK_RETRY) begin
               ack_code_next = tgt_ack;
               state_next    = ST_RELEASE;
            end
`ifdef BUS_ARB_TIMEOUT_EN
            else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
               ack_code_next = ACK_RETRY;
               state_next    = ST_RELEASE;
            end
`endif
         end
         ST_RELEASE: begin
            if ((grant_reg & req_vec) == '0) begin
               last_next  = IDX_W'(onehot_idx(8'(grant_reg)));
               grant_next = '0;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Outputs are derived from the next state so they are registered (Moore).
      busy_next     = (state_next != ST_IDLE);
      tgt_send_next = (state_next == ST_XFER) ? SEND_REQ : SEND_IDLE;
      req_ack_next  = '0;
      if (state_next == ST_RELEASE) begin
         for (int i = 0; i < NREQ; i++) begin
            if (grant_next[i]) req_ack_next[2*i +: 2] = ack_code_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         grant_reg    <= '0;
         tgt_dado_reg <= '0;
         tgt_send_reg <= SEND_IDLE;
         ack_code_reg <= ACK_NONE;
         req_ack_reg  <= '0;
         busy_reg     <= 1'b0;
         last_reg     <= IDX_W'(NREQ - 1);
      end else begin
         state_reg    <= state_next;
         grant_reg    <= grant_next;
         tgt_dado_reg <= tgt_dado_next;
         tgt_send_reg <= tgt_send_next;
         ack_code_reg <= ack_code_next;
         req_ack_reg  <= req_ack_next;
         busy_reg     <= busy_next;
         last_reg     <= last_next;
      end
   end

   assign grant    = grant_reg;
   assign busy     = busy_reg;
   assign tgt_send = tgt_send_reg;
   assign tgt_dado = tgt_dado_reg;
   assign req_ack  = req_ack_reg;

endmodule
